// File: rtl/spiflash_cmd_seq.sv
// spiflash_cmd_seq: sequences flash RDSR/SE4K/PP/BE64K ops through the
// spimemio config Wishbone port, then restores memory-mapped mode.
// Ports: cmd_* request (op/addr/len), wr_* PP payload stream,
//   busy/done/err/status_o result, m_* config-port Wishbone master.
// Build option: define SPIFLASH_SEQ_TIMEOUT_EN to bound WIP polling
//   to POLL_LIMIT polls and raise err on expiry.
module spiflash_cmd_seq #(
  parameter int unsigned POLL_GAP   = 256,
  parameter logic [23:0] POLL_LIMIT = 24'hFFFFFF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [23:0] cmd_addr,
  input  logic [8:0]  cmd_len,
  input  logic [7:0]  wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  status_o,
  output logic [2:0]  m_adr_o,
  output logic [31:0] m_dat_o,
  output logic [3:0]  m_sel_o,
  output logic        m_we_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i
);

  localparam int unsigned GW = $clog2(POLL_GAP + 2);
  localparam logic [31:0] CSLO = 32'h0000_0D0C;
  localparam logic [31:0] CSHI = 32'h0000_0D2C;
  localparam logic [31:0] RSTR = 32'h8000_0000;

  typedef enum logic [4:0] {
    IDLE, ENTER, WREN_LO, WREN_B, WREN_HI,
    CMD_LO, CMD_B, ADDR_B, DATA, CMD_HI,
    GAP, POLL_LO, POLL_OP, POLL_D, POLL_RD,
    POLL_HI, EXIT, DONE
  } state_e;

  state_e state_q, state_d;

  logic [1:0]    op_q;
  logic [23:0]   addr_q;
  logic [8:0]    len_q;
  logic [1:0]    idx_q;
  logic [7:0]    byte_q;
  logic          have_q;
  logic          hold_q;
  logic [GW-1:0] gap_q;
  logic [7:0]    status_q;

  logic       bus_req;
  logic       ack;
  logic       accept;
  logic       is_rd;
  logic       tmo;
  logic [7:0] opc;
  logic [7:0] abyte;
  logic [7:0] tx_byte;

  logic unused_dat;
  assign unused_dat = ^m_dat_i[31:8];

  assign is_rd  = (op_q == 2'b00);
  assign accept = (state_q == IDLE) && cmd_valid;
  // hold_q forces one idle bus cycle after every ack
  assign m_cyc_o = bus_req && !hold_q;
  assign m_stb_o = m_cyc_o;
  assign ack     = m_ack_i && m_cyc_o;

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign done      = (state_q == DONE);
  assign status_o  = status_q;
  assign wr_ready  = (state_q == DATA) && !have_q && wr_valid;

`ifdef SPIFLASH_SEQ_TIMEOUT_EN
  logic [23:0] pcnt_q;
  logic        err_q;

  assign tmo = (pcnt_q + 24'd1) == POLL_LIMIT;
  assign err = err_q;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      pcnt_q <= '0;
      err_q  <= 1'b0;
    end else if (accept) begin
      pcnt_q <= '0;
      err_q  <= 1'b0;
    end else if (state_q == POLL_HI && ack &&
                 !is_rd && status_q[0]) begin
      pcnt_q <= pcnt_q + 24'd1;
      if (tmo) err_q <= 1'b1;
    end
  end
`else
  logic unused_lim;
  assign unused_lim = ^POLL_LIMIT;
  assign tmo = 1'b0;
  assign err = 1'b0;
`endif

  always_comb begin
    opc = 8'h05;
    unique case (op_q)
      2'b00: opc = 8'h05;
      2'b01: opc = 8'h20;
      2'b10: opc = 8'h02;
      2'b11: opc = 8'hD8;
    endcase
  end

  always_comb begin
    abyte = addr_q[7:0];
    unique case (idx_q)
      2'd0:    abyte = addr_q[23:16];
      2'd1:    abyte = addr_q[15:8];
      default: abyte = addr_q[7:0];
    endcase
  end

  always_comb begin
    tx_byte = 8'h00;
    unique case (state_q)
      WREN_B:  tx_byte = 8'h06;
      CMD_B:   tx_byte = opc;
      ADDR_B:  tx_byte = abyte;
      DATA:    tx_byte = byte_q;
      POLL_OP: tx_byte = 8'h05;
      default: tx_byte = 8'h00;
    endcase
  end

  // state register
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state_q <= IDLE;
    else            state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_valid) state_d = ENTER;
      ENTER:   if (ack) state_d = is_rd ? CMD_LO : WREN_LO;
      WREN_LO: if (ack) state_d = WREN_B;
      WREN_B:  if (ack) state_d = WREN_HI;
      WREN_HI: if (ack) state_d = CMD_LO;
      CMD_LO:  if (ack) state_d = CMD_B;
      CMD_B:   if (ack) state_d = is_rd ? POLL_D : ADDR_B;
      ADDR_B:
        if (ack && idx_q == 2'd2)
          state_d = (op_q == 2'b10) ? DATA : CMD_HI;
      DATA:    if (ack && len_q == 9'd1) state_d = CMD_HI;
      CMD_HI:  if (ack) state_d = GAP;
      GAP:
        if (gap_q == GW'(POLL_GAP)) state_d = POLL_LO;
      POLL_LO: if (ack) state_d = POLL_OP;
      POLL_OP: if (ack) state_d = POLL_D;
      POLL_D:  if (ack) state_d = POLL_RD;
      POLL_RD: if (ack) state_d = POLL_HI;
      POLL_HI:
        if (ack) begin
          if (is_rd || !status_q[0] || tmo) state_d = EXIT;
          else                               state_d = GAP;
        end
      EXIT:    if (ack) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs
  always_comb begin
    bus_req = 1'b1;
    m_we_o  = 1'b1;
    m_adr_o = 3'b000;
    m_sel_o = 4'b0011;
    m_dat_o = CSHI;
    unique case (state_q)
      ENTER, WREN_HI, CMD_HI, POLL_HI: m_dat_o = CSHI;
      WREN_LO, CMD_LO, POLL_LO:        m_dat_o = CSLO;
      WREN_B, CMD_B, ADDR_B, POLL_OP, POLL_D, DATA: begin
        bus_req = (state_q != DATA) || have_q;
        m_adr_o = 3'b100;
        m_sel_o = 4'b0001;
        m_dat_o = {24'h0, tx_byte};
      end
      POLL_RD: begin
        m_we_o  = 1'b0;
        m_adr_o = 3'b100;
        m_sel_o = 4'b0001;
        m_dat_o = '0;
      end
      EXIT: begin
        m_sel_o = 4'b1000;
        m_dat_o = RSTR;
      end
      default: begin
        bus_req = 1'b0;
        m_we_o  = 1'b0;
        m_sel_o = 4'b0000;
        m_dat_o = '0;
      end
    endcase
  end

  // datapath
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      op_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      idx_q    <= '0;
      byte_q   <= '0;
      have_q   <= 1'b0;
      hold_q   <= 1'b0;
      gap_q    <= '0;
      status_q <= '0;
    end else begin
      hold_q <= ack;
      gap_q  <= (state_q == GAP) ? gap_q + GW'(1) : '0;
      if (accept) begin
        op_q   <= cmd_op;
        addr_q <= cmd_addr;
        len_q  <= (cmd_len == 9'd0) ? 9'd256 : cmd_len;
        idx_q  <= '0;
        have_q <= 1'b0;
      end
      if (wr_ready) begin
        have_q <= 1'b1;
        byte_q <= wr_data;
      end
      if (ack && state_q == ADDR_B) idx_q <= idx_q + 2'd1;
      if (ack && state_q == DATA) begin
        have_q <= 1'b0;
        len_q  <= len_q - 9'd1;
      end
      if (ack && state_q == POLL_RD) status_q <= m_dat_i[7:0];
    end
  end

endmodule

// File: tb/tb_spiflash_cmd_seq.sv
// tb_spiflash_cmd_seq: scoreboard bench for spiflash_cmd_seq.
// Random-latency Wishbone slave checks every bus op against expectations.
module tb_spiflash_cmd_seq;

  typedef struct packed {
    logic        we;
    logic [2:0]  adr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } bus_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [23:0] cmd_addr;
  logic [8:0]  cmd_len;
  logic [7:0]  wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic        busy;
  logic        done;
  logic        err;
  logic [7:0]  status_o;
  logic [2:0]  m_adr_o;
  logic [31:0] m_dat_o;
  logic [3:0]  m_sel_o;
  logic        m_we_o;
  logic        m_cyc_o;
  logic        m_stb_o;
  logic [31:0] m_dat_i;
  logic        m_ack_i;

  bus_t       exp_q[$];
  logic [7:0] rdq[$];
  logic [7:0] pay_q[$];
  int n_chk = 0;
  int n_fail = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  spiflash_cmd_seq #(
    .POLL_GAP(4),
    .POLL_LIMIT(24'd4)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_ni(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_op(cmd_op),
    .cmd_addr(cmd_addr),
    .cmd_len(cmd_len),
    .wr_data(wr_data),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .busy(busy),
    .done(done),
    .err(err),
    .status_o(status_o),
    .m_adr_o(m_adr_o),
    .m_dat_o(m_dat_o),
    .m_sel_o(m_sel_o),
    .m_we_o(m_we_o),
    .m_cyc_o(m_cyc_o),
    .m_stb_o(m_stb_o),
    .m_dat_i(m_dat_i),
    .m_ack_i(m_ack_i)
  );

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void pw(input logic [2:0] a,
                             input logic [3:0] s,
                             input logic [31:0] d);
    exp_q.push_back(bus_t'{we:1'b1, adr:a, sel:s, dat:d});
  endfunction

  function automatic void pcshi();
    pw(3'b000, 4'b0011, 32'h0000_0D2C);
  endfunction

  function automatic void pcslo();
    pw(3'b000, 4'b0011, 32'h0000_0D0C);
  endfunction

  function automatic void pb(input logic [7:0] b);
    pw(3'b100, 4'b0001, {24'h0, b});
  endfunction

  function automatic void prd();
    exp_q.push_back(bus_t'{we:1'b0, adr:3'b100,
                           sel:4'b0001, dat:32'h0});
  endfunction

  function automatic void prest();
    pw(3'b000, 4'b1000, 32'h8000_0000);
  endfunction

  function automatic void pwren();
    pcslo(); pb(8'h06); pcshi();
  endfunction

  function automatic void pframe();
    pcslo(); pb(8'h05); pb(8'h00); prd(); pcshi();
  endfunction

  function automatic void phead(input logic [7:0] opc,
                                input logic [23:0] a);
    pcshi(); pwren(); pcslo(); pb(opc);
    pb(a[23:16]); pb(a[15:8]); pb(a[7:0]);
  endfunction

  // Wishbone slave + bus monitor
  initial begin
    int   dly;
    bit   pend;
    bus_t e;
    logic [7:0]  rb;
    logic [39:0] act;
    m_ack_i = 1'b0;
    m_dat_i = '0;
    pend = 1'b0;
    dly = 0;
    forever begin
      @(posedge clk); #1;
      if (!rst_n) begin
        m_ack_i = 1'b0;
        pend = 1'b0;
      end else if (m_ack_i) begin
        m_ack_i = 1'b0;
        pend = 1'b0;
        chk("cyc_after_ack", {m_cyc_o, m_stb_o}, 0);
      end else if (m_cyc_o && m_stb_o) begin
        if (!pend) begin
          pend = 1'b1;
          dly = $urandom_range(0, 20);
        end
        if (dly == 0) begin
          m_ack_i = 1'b1;
          if (!m_we_o) begin
            rb = (rdq.size() > 0) ? rdq.pop_front() : 8'h00;
            m_dat_i = {24'hA5A5A5, rb};
          end
          act = {m_we_o, m_adr_o, m_sel_o,
                 m_we_o ? m_dat_o : 32'h0};
          if (exp_q.size() == 0) begin
            chk("bus_unexpected", act, 0);
          end else begin
            e = exp_q.pop_front();
            chk("bus_op", act, e);
          end
        end else begin
          dly--;
        end
      end
    end
  end

  // payload feeder, wr_valid toggled at random
  initial begin
    bit hs;
    bit vld;
    wr_valid = 1'b0;
    wr_data = 8'h00;
    forever begin
      @(negedge clk);
      hs = wr_ready;
      vld = wr_valid;
      @(posedge clk); #1;
      if (hs) begin
        pulses++;
        if (vld && pay_q.size() > 0) void'(pay_q.pop_front());
      end
      wr_valid = (pay_q.size() > 0) && ($urandom_range(0, 1) == 1);
      wr_data = (pay_q.size() > 0) ? pay_q[0] : 8'h00;
    end
  end

  task automatic issue(input logic [1:0] op,
                       input logic [23:0] a,
                       input logic [8:0] l);
    @(negedge clk);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_addr = a;
    cmd_len = l;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("busy_after_accept", busy, 1);
    chk("err_after_accept", err, 0);
  endtask

  task automatic wait_done(input string nm,
                           input logic e_err,
                           input logic [7:0] e_st);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!done && t < 40000);
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_timeout: got no done expected done", nm);
      return;
    end
    chk({nm, "_busy"}, busy, 0);
    chk({nm, "_err"}, err, e_err);
    chk({nm, "_status"}, status_o, e_st);
    chk({nm, "_exp_left"}, exp_q.size(), 0);
    @(negedge clk);
    chk({nm, "_done_pulse"}, done, 0);
    chk({nm, "_ready"}, cmd_ready, 1);
  endtask

  initial begin
    int base;
    int t;
    logic [7:0] b;
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    cmd_addr = '0;
    cmd_len = '0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_status", status_o, 0);
    chk("rst_cyc", m_cyc_o, 0);
    chk("rst_stb", m_stb_o, 0);
    chk("rst_we", m_we_o, 0);
    chk("rst_wr_ready", wr_ready, 0);
    rst_n = 1'b1;

    // RDSR
    rdq.push_back(8'h40);
    pcshi(); pframe(); prest();
    issue(2'b00, 24'hFFFFFF, 9'd0);
    wait_done("rdsr", 1'b0, 8'h40);

    // SE4K, WIP for 3 polls; cmd_valid while busy ignored
    rdq = '{8'h01, 8'h01, 8'h01, 8'h00};
    phead(8'h20, 24'h012345); pcshi();
    repeat (4) pframe();
    prest();
    issue(2'b01, 24'h012345, 9'd0);
    cmd_valid = 1'b1;
    cmd_op = 2'b00;
    repeat (5) @(negedge clk);
    cmd_valid = 1'b0;
    wait_done("se4k", 1'b0, 8'h00);

    // PP len=0 -> 256 bytes
    rdq = '{8'h03, 8'h00};
    phead(8'h02, 24'hABCDEF);
    for (int i = 0; i < 256; i++) begin
      b = 8'(i * 7 + 3);
      pb(b);
      pay_q.push_back(b);
    end
    pcshi(); pframe(); pframe(); prest();
    base = pulses;
    issue(2'b10, 24'hABCDEF, 9'd0);
    wait_done("pp256", 1'b0, 8'h00);
    chk("pp256_wr_ready_pulses", pulses - base, 256);

    // BE64K, ready at first poll
    rdq.push_back(8'h00);
    phead(8'hD8, 24'h00FF00); pcshi(); pframe(); prest();
    issue(2'b11, 24'h00FF00, 9'd0);
    wait_done("be64k", 1'b0, 8'h00);

    // PP len=1
    rdq.push_back(8'h00);
    phead(8'h02, 24'h000100);
    pb(8'h9C);
    pay_q.push_back(8'h9C);
    pcshi(); pframe(); prest();
    base = pulses;
    issue(2'b10, 24'h000100, 9'd1);
    wait_done("pp1", 1'b0, 8'h00);
    chk("pp1_wr_ready_pulses", pulses - base, 1);

    // reset in the middle of a PP
    phead(8'h02, 24'h001000);
    for (int i = 0; i < 20; i++) begin
      b = 8'(8'hC0 + i);
      pb(b);
      pay_q.push_back(b);
    end
    base = pulses;
    issue(2'b10, 24'h001000, 9'd20);
    t = 0;
    while (pulses - base < 10 && t < 5000) begin
      @(negedge clk);
      t++;
    end
    chk("midpp_reached_byte10", (pulses - base >= 10), 1);
    rst_n = 1'b0;
    exp_q.delete();
    pay_q.delete();
    rdq.delete();
    #1;
    chk("midpp_rst_cyc", m_cyc_o, 0);
    chk("midpp_rst_busy", busy, 0);
    chk("midpp_rst_ready", cmd_ready, 1);
    repeat (2) @(negedge clk);
    chk("midpp_rst_quiet", m_cyc_o, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    rdq.push_back(8'h7E);
    pcshi(); pframe(); prest();
    issue(2'b00, 24'h000000, 9'd0);
    wait_done("rdsr_after_rst", 1'b0, 8'h7E);

`ifdef SPIFLASH_SEQ_TIMEOUT_EN
    // WIP stuck -> 4 polls then err
    rdq = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
    phead(8'h20, 24'h000000); pcshi();
    repeat (4) pframe();
    prest();
    issue(2'b01, 24'h000000, 9'd0);
    wait_done("timeout", 1'b1, 8'h01);
    rdq.delete();
`endif

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
